// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed audio FIR.
// Default coefficient set is a 32-tap symmetric low-pass in Q1.17.
package fir_pkg;

  localparam int SAMPLE_W       = 24;
  localparam int COEF_W_DEFAULT = 18;
  localparam int MAX_TAPS       = 240;
  localparam int NTAPS_DEFAULT  = 32;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    ROUND
  } fir_state_e;

  localparam logic [NTAPS_DEFAULT-1:0][COEF_W_DEFAULT-1:0] FIR_COEFS = {
    18'd200,  18'd400,  18'd700,  18'd1000, 18'd1400, 18'd1900, 18'd2400, 18'd3000,
    18'd3600, 18'd4200, 18'd4800, 18'd5300, 18'd5800, 18'd6200, 18'd6500, 18'd6700,
    18'd6700, 18'd6500, 18'd6200, 18'd5800, 18'd5300, 18'd4800, 18'd4200, 18'd3600,
    18'd3000, 18'd2400, 18'd1900, 18'd1400, 18'd1000, 18'd700,  18'd400,  18'd200
  };

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write port at wr_ptr, one registered read port
// addressed as an age offset behind wr_ptr (a same-cycle write is forwarded).
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = 32,
  localparam int PTR_W = $clog2(NTAPS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic signed [SAMPLE_W-1:0] i_wr_dat,
  input  logic                       i_ptr_adv,
  input  logic        [PTR_W-1:0]    i_rd_tap,
  output logic signed [SAMPLE_W-1:0] o_rd_dat
);

  logic signed [SAMPLE_W-1:0] mem_q [NTAPS];
  logic signed [SAMPLE_W-1:0] mem_d [NTAPS];
  logic        [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic signed [SAMPLE_W-1:0] rd_dat_q, rd_dat_d;
  logic        [PTR_W:0]      rd_sum;
  logic        [PTR_W-1:0]    rd_addr;

  always_comb begin
    mem_d = mem_q;
    if (i_wr_en) mem_d[wr_ptr_q] = i_wr_dat;

    // (wr_ptr - tap) mod NTAPS without a divider
    rd_sum = {1'b0, wr_ptr_q} + (PTR_W+1)'(NTAPS) - {1'b0, i_rd_tap};
    if (rd_sum >= (PTR_W+1)'(NTAPS)) rd_addr = PTR_W'(rd_sum - (PTR_W+1)'(NTAPS));
    else                             rd_addr = PTR_W'(rd_sum);

    if (i_wr_en && (rd_addr == wr_ptr_q)) rd_dat_d = i_wr_dat;
    else                                  rd_dat_d = mem_q[rd_addr];

    wr_ptr_d = wr_ptr_q;
    if (i_ptr_adv) begin
      if (wr_ptr_q == PTR_W'(NTAPS-1)) wr_ptr_d = '0;
      else                             wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_dat_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  assign o_rd_dat = rd_dat_q;

endmodule

// File: rtl/audio_fir.sv
// Time-multiplexed FIR, one MAC per clock, NTAPS+3 clock latency; ticks while busy are dropped (sticky o_overrun).
// FIR_SATURATE_EN clamps the rounded result to 24 bits instead of wrapping.
module audio_fir
  import fir_pkg::*;
#(
  parameter int                            NTAPS  = NTAPS_DEFAULT,
  parameter int                            COEF_W = COEF_W_DEFAULT,
  parameter logic [NTAPS-1:0][COEF_W-1:0] COEFS  = FIR_COEFS
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_sample_tick,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  output logic signed [SAMPLE_W-1:0] o_sample,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_overrun
);

  localparam int PTR_W  = $clog2(NTAPS);
  localparam int PROD_W = SAMPLE_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);

  localparam logic signed [ACC_W-1:0] RND_K   = ACC_W'(1) << (COEF_W-2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(SAMPLE_W-1)));

  fir_state_e                 state_q, state_d;
  logic        [PTR_W-1:0]    idx_q, idx_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic                       prod_vld_q, prod_vld_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_W-1:0] sample_q, sample_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       overrun_q, overrun_d;

  logic                       wr_en, ptr_adv;
  logic        [PTR_W-1:0]    rd_tap;
  logic signed [SAMPLE_W-1:0] rd_dat;
  logic signed [COEF_W-1:0]   coef;
  logic signed [PROD_W-1:0]   rd_ext, coef_ext;
  logic signed [ACC_W-1:0]    rnd, shifted;
  logic signed [SAMPLE_W-1:0] res;

  fir_delay_line #(.NTAPS(NTAPS)) u_dly (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (wr_en),
    .i_wr_dat  (i_sample),
    .i_ptr_adv (ptr_adv),
    .i_rd_tap  (rd_tap),
    .o_rd_dat  (rd_dat)
  );

  always_comb begin
    coef     = COEFS[idx_q];
    rd_ext   = PROD_W'(rd_dat);
    coef_ext = PROD_W'(coef);
    prod_d   = rd_ext * coef_ext;

    rnd     = acc_q + RND_K;
    shifted = rnd >>> (COEF_W-1);
`ifdef FIR_SATURATE_EN
    if (shifted > SAT_MAX)      res = SAT_MAX[SAMPLE_W-1:0];
    else if (shifted < SAT_MIN) res = SAT_MIN[SAMPLE_W-1:0];
    else                        res = shifted[SAMPLE_W-1:0];
`else
    res = shifted[SAMPLE_W-1:0];
`endif
  end

`ifndef FIR_SATURATE_EN
  logic unused_hi;
  assign unused_hi = ^shifted[ACC_W-1:SAMPLE_W];
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    busy_d     = (state_q != IDLE) || i_sample_tick;
    overrun_d  = overrun_q || (i_sample_tick && (state_q != IDLE));
    prod_vld_d = (state_q == MAC);
    wr_en      = 1'b0;
    ptr_adv    = 1'b0;
    rd_tap     = '0;

    // Products land one cycle after their read; accumulate them as they arrive.
    if (prod_vld_q) acc_d = acc_q + ACC_W'(prod_q);

    case (state_q)
      IDLE: begin
        if (i_sample_tick) begin
          wr_en   = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        // Prefetch the next tap so the read register is ready at idx+1.
        rd_tap = idx_q + PTR_W'(1);
        if (idx_q == PTR_W'(NTAPS-1)) state_d = DRAIN;
        else                          idx_d   = idx_q + PTR_W'(1);
      end
      DRAIN: state_d = ROUND;
      ROUND: begin
        sample_d = res;
        valid_d  = 1'b1;
        ptr_adv  = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_sample  = sample_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_audio_fir.sv
// Three audio_fir instances (default low-pass, identity, all-max coefficients) share one input stream;
// a convolution reference model feeds per-instance expected-output queues.
module tb_audio_fir;
  import fir_pkg::*;

  localparam int NT = 32;
  localparam logic [NT-1:0][17:0] ID_COEFS  = {{(NT-1){18'd0}}, 18'h1FFFF};
  localparam logic [NT-1:0][17:0] MAX_COEFS = {NT{18'h1FFFF}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [23:0] smp = '0;

  logic [23:0] osmp  [3];
  logic        ovld  [3];
  logic        obusy [3];
  logic        oovr  [3];

  int checks = 0;
  int failures = 0;

  logic signed [23:0] hist [NT];
  logic signed [17:0] coef_tab [3][NT];
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] q2[$];

  always #5 clk = ~clk;

  audio_fir u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_sample(smp),
    .o_sample(osmp[0]), .o_valid(ovld[0]), .o_busy(obusy[0]), .o_overrun(oovr[0])
  );
  audio_fir #(.NTAPS(NT), .COEF_W(18), .COEFS(ID_COEFS)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_sample(smp),
    .o_sample(osmp[1]), .o_valid(ovld[1]), .o_busy(obusy[1]), .o_overrun(oovr[1])
  );
  audio_fir #(.NTAPS(NT), .COEF_W(18), .COEFS(MAX_COEFS)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_sample(smp),
    .o_sample(osmp[2]), .o_valid(ovld[2]), .o_busy(obusy[2]), .o_overrun(oovr[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_out(input int u);
    longint acc;
    acc = 0;
    for (int i = 0; i < NT; i++) acc += longint'(hist[i]) * longint'(coef_tab[u][i]);
    acc = (acc + 64'sd65536) >>> 17;
`ifdef FIR_SATURATE_EN
    if (acc > 64'sd8388607)       acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
`endif
    return acc[23:0];
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the tick is sampled at the next edge and the task returns 1 ns after it.
  task automatic drive_tick(input logic [23:0] s, input bit accepted);
    if (accepted) begin
      for (int i = NT-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = s;
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
      q2.push_back(model_out(2));
    end
    smp  = s;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic check_out(input int u, input logic [23:0] obs);
    logic [23:0] exp;
    int sz;
    sz = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
    checks++;
    assert (sz > 0) else begin
      failures++;
      $error("FAIL sb_unexpected_valid%0d observed=%0h expected=none", u, obs);
    end
    if (sz > 0) begin
      if (u == 0)      exp = q0.pop_front();
      else if (u == 1) exp = q1.pop_front();
      else             exp = q2.pop_front();
      chk($sformatf("sb_sample%0d", u), 32'(obs), 32'(exp));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 3; u++) if (ovld[u]) check_out(u, osmp[u]);
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      step(1);
      n++;
    end
    chk("sb_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("%s_sample%0d", tag, u), 32'(osmp[u]), 32'd0);
      chk($sformatf("%s_valid%0d", tag, u), 32'(ovld[u]), 32'd0);
      chk($sformatf("%s_busy%0d", tag, u), 32'(obusy[u]), 32'd0);
      chk($sformatf("%s_overrun%0d", tag, u), 32'(oovr[u]), 32'd0);
    end
  endtask

  task automatic impulse();
    drive_tick(24'h400000, 1'b1);
    // Spacing of NTAPS+3 lands each tick on the edge where busy falls.
    for (int j = 0; j < NT; j++) begin
      step(NT + 2);
      drive_tick(24'h000000, 1'b1);
    end
    step(NT + 4);
  endtask

  initial begin
    logic [NT-1:0][17:0] c0;
    logic [NT-1:0][17:0] c1;
    logic [NT-1:0][17:0] c2;
    logic [23:0] id_exp;
    longint full;
    logic [23:0] sat_exp;

    c0 = FIR_COEFS;
    c1 = ID_COEFS;
    c2 = MAX_COEFS;
    for (int i = 0; i < NT; i++) begin
      coef_tab[0][i] = c0[i];
      coef_tab[1][i] = c1[i];
      coef_tab[2][i] = c2[i];
      hist[i] = '0;
    end

    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Impulse response, back-to-back ticks at the minimum spacing.
    impulse();
    drain();
    chk("no_overrun_at_min_spacing", 32'(oovr[0]), 32'd0);

    // Identity coefficient: exact latency and busy window.
    drive_tick(24'h123456, 1'b1);
    id_exp = model_out(1);
    chk("busy_rise", 32'(obusy[1]), 32'd1);
    step(NT + 1);
    chk("valid_early", 32'(ovld[1]), 32'd0);
    chk("busy_before_done", 32'(obusy[1]), 32'd1);
    step(1);
    chk("valid_at_latency", 32'(ovld[1]), 32'd1);
    chk("busy_in_valid_cycle", 32'(obusy[1]), 32'd1);
    chk("identity_sample", 32'(osmp[1]), 32'(id_exp));
    step(1);
    chk("busy_fall", 32'(obusy[1]), 32'd0);
    chk("valid_one_cycle", 32'(ovld[1]), 32'd0);
    chk("sample_held", 32'(osmp[1]), 32'(id_exp));
    step(2);

    // Saturation / wrap with full-scale positive then negative input.
    for (int j = 0; j < NT; j++) begin
      drive_tick(24'h7FFFFF, 1'b1);
      step(NT + 3);
    end
    drain();
    full = (longint'(NT) * 64'sd8388607 * 64'sd131071 + 64'sd65536) >>> 17;
`ifdef FIR_SATURATE_EN
    sat_exp = 24'h7FFFFF;
`else
    sat_exp = full[23:0];
`endif
    chk("sat_pos", 32'(osmp[2]), 32'(sat_exp));
    for (int j = 0; j < NT; j++) begin
      drive_tick(24'h800000, 1'b1);
      step(NT + 3);
    end
    drain();
    full = (longint'(NT) * -64'sd8388608 * 64'sd131071 + 64'sd65536) >>> 17;
`ifdef FIR_SATURATE_EN
    sat_exp = 24'h800000;
`else
    sat_exp = full[23:0];
`endif
    chk("sat_neg", 32'(osmp[2]), 32'(sat_exp));

    // Overrun: second tick 5 clocks after the first is dropped.
    chk("overrun_before", 32'(oovr[0]), 32'd0);
    drive_tick(24'h0ABCDE, 1'b1);
    step(4);
    drive_tick(24'h654321, 1'b0);
    chk("overrun_set", 32'(oovr[0]), 32'd1);
    chk("busy_during_overrun", 32'(obusy[0]), 32'd1);
    step(NT + 3);
    for (int j = 0; j < 4; j++) begin
      drive_tick(24'(j * 300000), 1'b1);
      step(NT + 3);
    end
    drain();
    chk("overrun_sticky", 32'(oovr[0]), 32'd1);

    // Reset in the middle of MAC.
    drive_tick(24'h3FFFFF, 1'b1);
    step(10);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q0.delete();
    q1.delete();
    q2.delete();
    for (int i = 0; i < NT; i++) hist[i] = '0;
    step(2);
    rst_n = 1'b1;
    step(2);
    impulse();
    drain();

    // Ramp across several wr_ptr wraps.
    for (int j = 0; j < 3 * NT; j++) begin
      drive_tick(24'(j * 87381 - 4194304), 1'b1);
      step(NT + 3);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
